// File: rtl/convolution_2by2_controller_if.sv
// ----------------------------------------------------------------------------
// convolution_2by2_controller_if
//
// Groups the start/result handshake and the datapath control bus of the
// 2x2 convolution sequencer. Clock and reset stay plain module ports.
//
//   start                                     sequencer <- host      begin one convolution
//   result_ready                              sequencer <- consumer  result accepted
//   convolution_2by2_out         [7:0]        sequencer <- datapath  result buffer read data
//   input_array_addr_in_2by2     [4:0]        sequencer -> datapath  input operand mux select
//   filter_ceiling_first_array_addr_in_2by2   sequencer -> datapath  ceiling_1 mux select
//   filter_ceiling_second_array_addr_in_2by2  sequencer -> datapath  ceiling_2 mux select
//   buffer_read_addr_in_2by2     [1:0]        sequencer -> datapath  result buffer select
//   sys_2by2_en                               sequencer -> datapath  systolic array enable
//   datapath_clr                              sequencer -> datapath  one-cycle clear pulse
//   busy, done                                sequencer -> host      status
//   result_valid, result_data, result_index   sequencer -> consumer  result port
//
// master = the sequencer (initiator of every address/enable); slave = the
// datapath/host/consumer side.
// ----------------------------------------------------------------------------
interface convolution_2by2_controller_if;
    logic       start;
    logic       result_ready;
    logic [7:0] convolution_2by2_out;
    logic [4:0] input_array_addr_in_2by2;
    logic [4:0] filter_ceiling_first_array_addr_in_2by2;
    logic [4:0] filter_ceiling_second_array_addr_in_2by2;
    logic [1:0] buffer_read_addr_in_2by2;
    logic       sys_2by2_en;
    logic       datapath_clr;
    logic       busy;
    logic       done;
    logic       result_valid;
    logic [7:0] result_data;
    logic [1:0] result_index;

    modport master (
        input  start,
        input  result_ready,
        input  convolution_2by2_out,
        output input_array_addr_in_2by2,
        output filter_ceiling_first_array_addr_in_2by2,
        output filter_ceiling_second_array_addr_in_2by2,
        output buffer_read_addr_in_2by2,
        output sys_2by2_en,
        output datapath_clr,
        output busy,
        output done,
        output result_valid,
        output result_data,
        output result_index
    );

    modport slave (
        output start,
        output result_ready,
        output convolution_2by2_out,
        input  input_array_addr_in_2by2,
        input  filter_ceiling_first_array_addr_in_2by2,
        input  filter_ceiling_second_array_addr_in_2by2,
        input  buffer_read_addr_in_2by2,
        input  sys_2by2_en,
        input  datapath_clr,
        input  busy,
        input  done,
        input  result_valid,
        input  result_data,
        input  result_index
    );
endinterface

// File: rtl/convolution_2by2_controller.sv
// ----------------------------------------------------------------------------
// convolution_2by2_controller
//
// Sequencer for the 2x2 convolution datapath. A start pulse in IDLE clears
// the datapath, streams the 16 input-array addresses with their paired
// filter addresses while the systolic array is enabled, drains the array
// skew, then reads the four results (C11, C12, C21, C22) back through the
// result buffer and hands them out on a valid/ready port.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   bus  - convolution_2by2_controller_if.master (handshake + datapath controls)
//
// Every output is a register; the next-state logic computes the value each
// output takes in the state being entered, so outputs line up with state.
// ----------------------------------------------------------------------------
module convolution_2by2_controller #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [4:0]  ZERO_ADDR    = 5'd25
) (
    input  logic                                clk,
    input  logic                                rst,
    convolution_2by2_controller_if.master       bus
);

    // One shared counter serves the flush drain and the read wait.
    localparam int unsigned CNT_MAX = (FLUSH_CYCLES > READ_LATENCY) ? FLUSH_CYCLES : READ_LATENCY;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        READ_WAIT,
        READ_OUT,
        DONE
    } state_e;

    // Filter select for ceiling_1: valid for the top-left 3x3 window of the
    // 4x4 feed grid, addressing the 3x3 filter block starting at 16.
    function automatic logic [4:0] ceil1_addr(input logic [3:0] idx);
        logic [1:0] r;
        logic [1:0] c;
        r = idx[3:2];
        c = idx[1:0];
        if (r != 2'd3 && c != 2'd3) begin
            return 5'd16 + 5'd3 * 5'(r) + 5'(c);
        end
        return ZERO_ADDR;
    endfunction

    // Filter select for ceiling_2: same filter rows, shifted one column right.
    function automatic logic [4:0] ceil2_addr(input logic [3:0] idx);
        logic [1:0] r;
        logic [1:0] c;
        r = idx[3:2];
        c = idx[1:0];
        if (r != 2'd3 && c != 2'd0) begin
            return 5'd16 + 5'd3 * 5'(r) + 5'(c) - 5'd1;
        end
        return ZERO_ADDR;
    endfunction

    state_e           state_q,    state_d;
    logic [3:0]       idx_q,      idx_d;
    logic [1:0]       rd_idx_q,   rd_idx_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [4:0]       in_addr_q,  in_addr_d;
    logic [4:0]       ceil1_q,    ceil1_d;
    logic [4:0]       ceil2_q,    ceil2_d;
    logic [1:0]       rd_addr_q,  rd_addr_d;
    logic             en_q,       en_d;
    logic             clr_q,      clr_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             valid_q,    valid_d;
    logic [7:0]       data_q,     data_d;
    logic [1:0]       index_q,    index_d;

    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_idx_d  = rd_idx_q;
        cnt_d     = cnt_q;
        in_addr_d = in_addr_q;
        ceil1_d   = ceil1_q;
        ceil2_d   = ceil2_q;
        rd_addr_d = rd_addr_q;
        en_d      = en_q;
        clr_d     = 1'b0;
        valid_d   = valid_q;
        data_d    = data_q;
        index_d   = index_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CLEAR;
                    clr_d     = 1'b1;
                    en_d      = 1'b0;
                    in_addr_d = ZERO_ADDR;
                    ceil1_d   = ZERO_ADDR;
                    ceil2_d   = ZERO_ADDR;
                    rd_addr_d = 2'd0;
                    idx_d     = 4'd0;
                    rd_idx_d  = 2'd0;
                    cnt_d     = '0;
                end
            end

            CLEAR: begin
                state_d   = FEED;
                en_d      = 1'b1;
                idx_d     = 4'd0;
                in_addr_d = 5'd0;
                ceil1_d   = ceil1_addr(4'd0);
                ceil2_d   = ceil2_addr(4'd0);
            end

            FEED: begin
                // idx wraps 15 -> 0 on the exit edge, leaving it cleared.
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d   = FLUSH;
                    cnt_d     = '0;
                    in_addr_d = ZERO_ADDR;
                    ceil1_d   = ZERO_ADDR;
                    ceil2_d   = ZERO_ADDR;
                end else begin
                    in_addr_d = {1'b0, idx_d};
                    ceil1_d   = ceil1_addr(idx_d);
                    ceil2_d   = ceil2_addr(idx_d);
                end
            end

            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d   = READ_WAIT;
                    cnt_d     = '0;
                    en_d      = 1'b0;
                    rd_addr_d = rd_idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            READ_WAIT: begin
                // Buffer data is valid once the address has been held for
                // READ_LATENCY cycles; capture it on the last wait edge.
                if (cnt_q == WAIT_LAST) begin
                    state_d = READ_OUT;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = bus.convolution_2by2_out;
                    index_d = rd_idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            READ_OUT: begin
                if (bus.result_ready) begin
                    valid_d = 1'b0;
                    if (rd_idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        state_d   = READ_WAIT;
                        rd_idx_d  = rd_idx_q + 2'd1;
                        rd_addr_d = rd_idx_q + 2'd1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            rd_idx_q  <= 2'd0;
            cnt_q     <= '0;
            in_addr_q <= ZERO_ADDR;
            ceil1_q   <= ZERO_ADDR;
            ceil2_q   <= ZERO_ADDR;
            rd_addr_q <= 2'd0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'd0;
            index_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_idx_q  <= rd_idx_d;
            cnt_q     <= cnt_d;
            in_addr_q <= in_addr_d;
            ceil1_q   <= ceil1_d;
            ceil2_q   <= ceil2_d;
            rd_addr_q <= rd_addr_d;
            en_q      <= en_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            index_q   <= index_d;
        end
    end

    assign bus.input_array_addr_in_2by2                 = in_addr_q;
    assign bus.filter_ceiling_first_array_addr_in_2by2  = ceil1_q;
    assign bus.filter_ceiling_second_array_addr_in_2by2 = ceil2_q;
    assign bus.buffer_read_addr_in_2by2                 = rd_addr_q;
    assign bus.sys_2by2_en                              = en_q;
    assign bus.datapath_clr                             = clr_q;
    assign bus.busy                                     = busy_q;
    assign bus.done                                     = done_q;
    assign bus.result_valid                             = valid_q;
    assign bus.result_data                              = data_q;
    assign bus.result_index                             = index_q;

endmodule

// File: doc/convolution_2by2_controller.md
Name: convolution_2by2_controller

Overview:
Sequencer that drives the 2x2 convolution datapath (input/filter operand muxes, 2x2 systolic array, result buffer). On a start pulse it clears the datapath and streams the 16 input-array addresses with their paired filter addresses while the array is enabled. It then flushes the array skew and reads the four results back through the buffer read address, handing them out on a valid/ready result port. It is the initiator for every address and enable input that the datapath consumes.

Parameters:
FLUSH_CYCLES, 3, cycles with enable high and zero operands after the last feed step (array skew drain)
READ_LATENCY, 1, cycles from buffer_read_addr change to valid convolution_2by2_out
ZERO_ADDR, 25, mux select that yields 8'b0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  begin one convolution; sampled only in IDLE
result_ready  in  1  consumer accepts result_data
convolution_2by2_out  in  8  buffer read data from datapath
input_array_addr_in_2by2  out  5  input operand mux select
filter_ceiling_first_array_addr_in_2by2  out  5  ceiling_1 mux select
filter_ceiling_second_array_addr_in_2by2  out  5  ceiling_2 mux select
buffer_read_addr_in_2by2  out  2  result buffer select
sys_2by2_en  out  1  systolic array enable
datapath_clr  out  1  one-cycle clear pulse; the top level ORs it into the datapath reset
busy  out  1  high from CLEAR through DONE, inclusive
done  out  1  one-cycle pulse at completion
result_valid  out  1  result_data valid
result_data  out  8  captured result
result_index  out  2  0=C11, 1=C12, 2=C21, 3=C22

Behaviour:
- All outputs are registered.
- Reset values: all three operand addrs = ZERO_ADDR; buffer_read_addr = 0; sys_2by2_en, datapath_clr, busy, done, result_valid = 0; result_data = 0; result_index = 0; state = IDLE; counters = 0.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> READ_WAIT <-> READ_OUT -> DONE -> IDLE.
- IDLE:
  - start=1 at an edge -> CLEAR.
  - start is ignored in every other state; a start arriving with DONE does not chain.
- CLEAR (1 cycle): datapath_clr=1, sys_2by2_en=0, addrs = ZERO_ADDR.
- FEED (16 cycles, idx 0..15, r=idx/4, c=idx%4): sys_2by2_en=1.
  - input addr = idx.
  - first filter addr = 16+3r+c if r<=2 and c<=2, else ZERO_ADDR.
  - second filter addr = 16+3r+(c-1) if r<=2 and 1<=c<=3, else ZERO_ADDR.
- FLUSH (FLUSH_CYCLES cycles): sys_2by2_en=1, all addrs = ZERO_ADDR.
- READ_WAIT:
  - sys_2by2_en=0; buffer_read_addr = rd_idx, held for READ_LATENCY cycles.
  - On the last wait edge, capture convolution_2by2_out into result_data and set result_index = rd_idx.
- READ_OUT:
  - result_valid=1; result_data and result_index are held stable while result_ready=0.
  - When result_valid && result_ready at an edge: result_valid drops. If rd_idx=3 -> DONE; otherwise rd_idx++ -> READ_WAIT.
- DONE (1 cycle): done=1, busy=1 -> IDLE; busy drops on the following edge.
- Latency: with result_ready tied high and default parameters, done is high in the 29th cycle after the start-sampling edge: 1 + 16 + 3 + 4*(READ_LATENCY+1) = 28 cycles, then DONE.
- Reset asserted mid-operation: immediate return to the reset values. The next start restarts from CLEAR and no partial result is re-emitted.
- Counters use exact widths: idx 4-bit, rd_idx 2-bit, plus a flush/wait counter sized for max(FLUSH_CYCLES, READ_LATENCY). idx wrap from 15 is the FEED exit, not a repeat.

Test Plan:
- Reset then start pulse -> datapath_clr=1 for exactly 1 cycle, then 16 FEED cycles with sys_2by2_en=1. Sampled triples (input, f1, f2): idx0 (0,16,25), idx3 (3,25,18), idx5 (5,20,19), idx10 (10,24,23), idx12 (12,25,25).
- FLUSH check -> exactly 3 cycles after idx15 with en=1 and all addrs=25, then en=0.
- result_ready tied 1, buffer model returns 8'h11/8'h22/8'h33/8'h44 for addr 0..3 after 1 cycle -> results emitted in order with result_index 0..3; done pulses once, in cycle 29 after the start edge; busy=0 in cycle 30.
- result_ready held 0 for 5 cycles at index 1 -> result_valid stays high with result_data=8'h22 and result_index=1 unchanged, buffer_read_addr stays 1, no advance until ready.
- start pulsed again during FEED and during READ_OUT -> ignored; the sequence and addresses are unchanged; exactly one done.
- rst driven low during FEED idx 7 -> all outputs reach reset values asynchronously. A new start then produces the full CLEAR/FEED sequence from idx 0.
